// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit-side buffer.
//
//   tx_fifo_state_t : launch controller states. GAP is only reachable when
//                     uart_tx_fifo is built with UART_TX_FIFO_GAP_EN.
//   UART_DATA_W     : width of one UART data byte.
//   ACT_TIMEOUT     : clocks the controller waits for the transmitter to
//                     report activity after a launch before giving up.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int ACT_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACT,
        WAIT_DONE,
        GAP
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock byte FIFO with occupancy count. A read and a write in the
//   same cycle both proceed; when full, a write is still accepted if a read
//   frees a slot in that cycle. Reads are show-ahead: rd_data always
//   presents the entry at the read pointer.
//
// Parameters
//   DEPTH   : number of entries, power of two, at least 2.
//   ADDR_W  : pointer width, derived from DEPTH.
//
// Ports
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (pointers and count)
//   wr_en    in   write request
//   wr_data  in   byte to write
//   rd_en    in   read request (ignored while empty)
//   rd_data  out  entry at the read pointer
//   wr_drop  out  write requested but not accepted this cycle
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   wr_drop,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count
);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic                   rd_ok;
    logic                   wr_ok;

    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // A read while full frees the slot the write lands in.
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign wr_drop = wr_en && !wr_ok;

    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;

            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, so clearing it would add logic for nothing.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte buffer and launch controller placed directly in front of a UART
//   transmitter. Host bytes are queued in a synchronous FIFO; the controller
//   pops one byte at a time, pulses o_TX_DV with the byte on o_TX_Byte, and
//   waits for the transmitter to finish the frame before launching the next.
//
//   Build option UART_TX_FIFO_GAP_EN: when defined, the controller idles for
//   GAP_CLKS clocks after each frame before the next launch. When undefined
//   there is no gap state or counter and GAP_CLKS is unused.
//
// Parameters
//   DEPTH    : FIFO entries, power of two, at least 2.
//   ADDR_W   : pointer width, derived from DEPTH.
//   GAP_CLKS : inter-frame idle clocks (UART_TX_FIFO_GAP_EN only), at least 1.
//
// Ports
//   i_Clock      in   system clock
//   i_Rst_L      in   synchronous active-low reset
//   i_Wr_DV      in   write strobe, one byte per asserted cycle
//   i_Wr_Byte    in   byte written when i_Wr_DV=1
//   o_Full       out  FIFO holds DEPTH bytes
//   o_Empty      out  FIFO holds no bytes
//   o_Count      out  FIFO occupancy, 0..DEPTH
//   o_Overflow   out  one-cycle pulse after a write was dropped
//   o_TX_DV      out  one-cycle launch pulse to the transmitter
//   o_TX_Byte    out  launched byte, held until the next launch
//   i_TX_Active  in   transmitter is sending a frame
//   i_TX_Done    in   transmitter finished a frame (one-cycle pulse)
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int GAP_CLKS = 217
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_L,
    input  logic                   i_Wr_DV,
    input  logic [UART_DATA_W-1:0] i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [ADDR_W:0]        o_Count,
    output logic                   o_Overflow,
    output logic                   o_TX_DV,
    output logic [UART_DATA_W-1:0] o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done
);

    localparam int                ACT_W    = $clog2(ACT_TIMEOUT);
    localparam logic [ACT_W-1:0]  ACT_LAST = ACT_W'(ACT_TIMEOUT - 1);

`ifdef UART_TX_FIFO_GAP_EN
    localparam tx_fifo_state_t AFTER_FRAME = GAP;
`else
    localparam tx_fifo_state_t AFTER_FRAME = IDLE;
`endif

    tx_fifo_state_t         state;
    tx_fifo_state_t         next_state;
    logic                   pop;
    logic                   wr_drop;
    logic [UART_DATA_W-1:0] fifo_data;
    logic [ACT_W-1:0]       act_cnt;
    logic                   tx_active_q;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (i_Clock),
        .rst_n   (i_Rst_L),
        .wr_en   (i_Wr_DV),
        .wr_data (i_Wr_Byte),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .wr_drop (wr_drop),
        .full    (o_Full),
        .empty   (o_Empty),
        .count   (o_Count)
    );

`ifdef UART_TX_FIFO_GAP_EN
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    logic [GAP_W-1:0] gap_cnt;

    // Loaded on entry to GAP and counted down to zero; GAP therefore lasts
    // exactly GAP_CLKS cycles.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            gap_cnt <= '0;
        end else if (state == WAIT_DONE && next_state == GAP) begin
            gap_cnt <= GAP_W'(GAP_CLKS - 1);
        end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;

        case (state)
            // o_Empty is registered, so a byte written this cycle cannot be
            // popped until the next one. !i_TX_Active also holds off a launch
            // while a frame begun before a reset is still on the line.
            IDLE: begin
                if (!o_Empty && !i_TX_Active) begin
                    pop        = 1'b1;
                    next_state = LAUNCH;
                end
            end

            LAUNCH: next_state = WAIT_ACT;

            // A transmitter that never goes active loses the byte; there is
            // no retry.
            WAIT_ACT: begin
                if (i_TX_Active) begin
                    next_state = WAIT_DONE;
                end else if (act_cnt == ACT_LAST) begin
                    next_state = IDLE;
                end
            end

            WAIT_DONE: begin
                if (i_TX_Done || (tx_active_q && !i_TX_Active)) begin
                    next_state = AFTER_FRAME;
                end
            end

`ifdef UART_TX_FIFO_GAP_EN
            GAP: begin
                if (gap_cnt == '0) next_state = IDLE;
            end
`endif

            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Overflow  <= 1'b0;
            act_cnt     <= '0;
            tx_active_q <= 1'b0;
        end else begin
            state       <= next_state;
            o_TX_DV     <= pop;
            o_Overflow  <= wr_drop;
            tx_active_q <= i_TX_Active;
            if (pop) o_TX_Byte <= fifo_data;
            // Counts cycles spent in WAIT_ACT; cleared everywhere else.
            act_cnt     <= (state == WAIT_ACT) ? act_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. A small transmitter stand-in answers each
//   launch with FRAME_CLKS cycles of activity ended by a done pulse, has no
//   reset, and logs the bytes it accepts. hold_active forces the line busy
//   and stub_en makes the stand-in ignore launches.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH      = 16;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int FRAME_CLKS = 24;

    // Clocks the line stays inactive between two back-to-back frames: done
    // edge, return to IDLE, pop edge, then the stand-in goes active again.
`ifdef UART_TX_FIFO_GAP_EN
    localparam int EXP_IDLE = 3 + 217;
`else
    localparam int EXP_IDLE = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_l;
    logic          wr_dv;
    logic [7:0]    wr_byte;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_active;
    logic          tx_done;

    logic          stub_en;
    logic          hold_active;
    logic          stub_active = 1'b0;
    logic          stub_done   = 1'b0;
    int            stub_cnt    = 0;
    int            collisions  = 0;
    logic [7:0]    sent_q [$];

    int            vectors     = 0;
    int            miscompares = 0;

    always #20 clk = ~clk;

    assign tx_active = stub_active | hold_active;
    assign tx_done   = stub_done;

    uart_tx_fifo #(
        .DEPTH    (DEPTH),
        .GAP_CLKS (217)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_l),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done)
    );

    // Transmitter stand-in.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (tx_dv && tx_active) collisions <= collisions + 1;
        if (stub_active) begin
            if (stub_cnt == 0) begin
                stub_active <= 1'b0;
                stub_done   <= 1'b1;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (tx_dv && stub_en) begin
            stub_active <= 1'b1;
            stub_cnt    <= FRAME_CLKS - 1;
            sent_q.push_back(tx_byte);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_dv   = 1'b1;
        wr_byte = b;
        @(negedge clk);
        wr_dv   = 1'b0;
    endtask

    // Wait for the queue and line to go quiet, then long enough for any
    // post-frame gap to expire.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((!empty || stub_active || tx_dv) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " drain in budget"}, 32'(n < budget), 32'd1);
        repeat (300) @(negedge clk);
    endtask

    initial begin
        int n;
        int idle;

        rst_l       = 1'b0;
        wr_dv       = 1'b0;
        wr_byte     = 8'h00;
        stub_en     = 1'b1;
        hold_active = 1'b0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;

        // Reset state.
        check("rst empty",    32'(empty),    32'd1);
        check("rst full",     32'(full),     32'd0);
        check("rst count",    32'(count),    32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst tx_dv",    32'(tx_dv),    32'd0);
        check("rst tx_byte",  32'(tx_byte),  32'h00);

        // Single byte: write at edge N, launch pulse over N+1..N+2.
        write_byte(8'hA5);
        check("t1 count after write", 32'(count), 32'd1);
        check("t1 no early launch",   32'(tx_dv), 32'd0);
        @(negedge clk);
        check("t1 launch",            32'(tx_dv),   32'd1);
        check("t1 launch byte",       32'(tx_byte), 32'hA5);
        check("t1 count after pop",   32'(count),   32'd0);
        @(negedge clk);
        check("t1 launch one cycle",  32'(tx_dv),   32'd0);
        check("t1 byte held",         32'(tx_byte), 32'hA5);
        drain("t1", 200);
        check("t1 frames sent",       32'(sent_q.size()), 32'd1);
        check("t1 sent byte",         32'(sent_q[0]),     32'hA5);

        // Burst to full while the line is held busy.
        sent_q.delete();
        hold_active = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        check("t2 full",  32'(full),  32'd1);
        check("t2 count", 32'(count), 32'd16);
        check("t2 empty", 32'(empty), 32'd0);

        // Write while full without a pop: dropped, one-cycle overflow.
        write_byte(8'hEE);
        check("t3 overflow pulse", 32'(overflow), 32'd1);
        check("t3 count held",     32'(count),    32'd16);
        @(negedge clk);
        check("t3 overflow ends",  32'(overflow), 32'd0);

        // Write while full on the pop cycle: accepted, count unchanged.
        hold_active = 1'b0;
        write_byte(8'hEE);
        check("t3 pop-cycle no overflow", 32'(overflow), 32'd0);
        check("t3 pop-cycle count",       32'(count),    32'd16);
        check("t3 pop-cycle launch",      32'(tx_dv),    32'd1);
        check("t3 pop-cycle byte",        32'(tx_byte),  32'h00);
        drain("t3", 8000);
        check("t3 frames sent", 32'(sent_q.size()), 32'd17);
        for (int i = 0; i < 16; i++)
            check($sformatf("t3 order %0d", i), 32'(sent_q[i]), 32'(i));
        check("t3 last byte", 32'(sent_q[16]), 32'hEE);
        check("t3 one launch per frame", 32'(collisions), 32'd0);

        // Reset mid-frame with five bytes queued.
        sent_q.delete();
        for (int i = 0; i < 6; i++) write_byte(8'h40 + 8'(i));
        check("t4 queued", 32'(count),       32'd5);
        check("t4 busy",   32'(stub_active), 32'd1);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        check("t4 flushed count", 32'(count),       32'd0);
        check("t4 flushed empty", 32'(empty),       32'd1);
        check("t4 tx_dv cleared", 32'(tx_dv),       32'd0);
        check("t4 tx_byte reset", 32'(tx_byte),     32'h00);
        check("t4 frame goes on", 32'(stub_active), 32'd1);
        write_byte(8'h3C);
        check("t4 held while line busy", 32'(count), 32'd1);
        n = 0;
        while (stub_active && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t4 frame ends", 32'(stub_active), 32'd0);
        n = 0;
        while (!tx_dv && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4 launch after frame", 32'(tx_dv),   32'd1);
        check("t4 launch byte",        32'(tx_byte), 32'h3C);
        drain("t4", 200);
        check("t4 frames sent",   32'(sent_q.size()), 32'd2);
        check("t4 partial frame", 32'(sent_q[0]),     32'h40);
        check("t4 next frame",    32'(sent_q[1]),     32'h3C);
        check("t4 no overlap",    32'(collisions),    32'd0);

        // Transmitter never goes active: four-cycle timeout, next byte goes.
        sent_q.delete();
        stub_en = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        check("t5 first launch", 32'(tx_dv),   32'd1);
        check("t5 first byte",   32'(tx_byte), 32'h11);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_dv && n < 20);
        check("t5 relaunch spacing", 32'(n),       32'd6);
        check("t5 second byte",      32'(tx_byte), 32'h22);
        check("t5 queue empty",      32'(count),   32'd0);
        repeat (20) @(negedge clk);
        stub_en = 1'b1;
        check("t5 nothing sent", 32'(sent_q.size()), 32'd0);

        // Inter-frame idle time on back-to-back frames.
        write_byte(8'h5A);
        write_byte(8'hC3);
        n = 0;
        while (!stub_active && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (stub_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        idle = 0;
        while (!stub_active && idle < 1000) begin
            idle++;
            @(negedge clk);
        end
        check("t6 inter-frame idle", 32'(idle), 32'(EXP_IDLE));
        drain("t6", 1000);
        check("t6 frames sent", 32'(sent_q.size()), 32'd2);
        check("t6 first byte",  32'(sent_q[0]),     32'h5A);
        check("t6 second byte", 32'(sent_q[1]),     32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
